ram_bus_master: RTL and testbench

Synchronous bus initiator that drives the shared 16-bit tri-state memory bus (data, address, rnw, cs_b) toward the on-chip 2K×16 block RAM and any peripheral that uses the same bus. It takes one request at a time over a valid/ready handshake and runs a read or write cycle on the bus. It returns a single-cycle response pulse, with read data for reads. It sits between a client (DMA/loader/debug port) and the memory bus. It is the initiator end of the protocol that the RAM answers.

---
 rtl/mem_bus_pkg.sv | 14 +
 rtl/ram_bus_master.sv | 105 ++++++++++
 tb/tb_ram_bus_master.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory-bus initiator: data width, wait-counter width, FSM states.
package mem_bus_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned WS_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_e;

endpackage

// File: rtl/ram_bus_master.sv
// Bus initiator: takes one valid/ready request at a time and runs a read or write
// cycle on the shared 16-bit tri-state memory bus, returning a one-cycle response.
module ram_bus_master
  import mem_bus_pkg::*;
#(
  parameter int unsigned AW          = 11,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rnw,
  input  logic [AW-1:0]     req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  inout  wire  [DATA_W-1:0] data,
  output logic [AW-1:0]     address,
  output logic              rnw,
  output logic              cs_b
);

  localparam logic [WS_W-1:0] WS = WS_W'(WAIT_STATES);

  state_e            state;
  logic [WS_W-1:0]   wait_cnt;
  logic              rd_first;
  logic [DATA_W-1:0] wdata_q;
  logic              drive_en;

  // Master drives the bus only while a write is selected; drive_en is a flop.
  assign data = drive_en ? wdata_q : {DATA_W{1'bz}};

  // FSM, wait counter, holding registers and all registered outputs.
  // Reads spend one extra cycle (rd_first) before counting, so the 4-bit counter
  // only ever holds WAIT_STATES and 2+WAIT_STATES read cycles never overflow it.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      rd_first  <= 1'b0;
      wdata_q   <= '0;
      drive_en  <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      cs_b      <= 1'b1;
      rnw       <= 1'b1;
      address   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            address   <= req_addr;
            wdata_q   <= req_wdata;
            wait_cnt  <= WS;
            cs_b      <= 1'b0;
            if (req_rnw) begin
              state    <= READ;
              rnw      <= 1'b1;
              rd_first <= 1'b1;
            end else begin
              state    <= WRITE;
              rnw      <= 1'b0;
              drive_en <= 1'b1;
            end
          end
        end
        READ: begin
          if (rd_first) begin
            rd_first <= 1'b0;
          end else if (wait_cnt == '0) begin
            rsp_rdata <= data;
            rsp_valid <= 1'b1;
            cs_b      <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt - WS_W'(1);
          end
        end
        WRITE: begin
          if (wait_cnt == '0) begin
            rsp_valid <= 1'b1;
            cs_b      <= 1'b1;
            rnw       <= 1'b1;
            drive_en  <= 1'b0;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt - WS_W'(1);
          end
        end
        RESP: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench for ram_bus_master: two instances (0 and 2 wait states), each on its own bus
// with a behavioural 2Kx16 synchronous RAM, checked against a transaction-level model.
module tb_ram_bus_master;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 16;

  typedef struct {
    bit          busy;
    bit          rnw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int          acc;
  } txn_t;

  logic          clk = 1'b0;
  logic          reset_b;
  logic          req_valid [2];
  logic          req_ready [2];
  logic          req_rnw   [2];
  logic [AW-1:0] req_addr  [2];
  logic [DW-1:0] req_wdata [2];
  logic          rsp_valid [2];
  logic [DW-1:0] rsp_rdata [2];
  logic [AW-1:0] address   [2];
  logic          rnw       [2];
  logic          cs_b      [2];
  wire  [DW-1:0] data0;
  wire  [DW-1:0] data1;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic rst_q  = 1'b0;

  ram_bus_master #(.AW(AW), .WAIT_STATES(0)) u_w0 (
    .clk(clk), .reset_b(reset_b),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_rnw(req_rnw[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .data(data0), .address(address[0]), .rnw(rnw[0]), .cs_b(cs_b[0])
  );

  ram_bus_master #(.AW(AW), .WAIT_STATES(2)) u_w2 (
    .clk(clk), .reset_b(reset_b),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_rnw(req_rnw[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .data(data1), .address(address[1]), .rnw(rnw[1]), .cs_b(cs_b[1])
  );

  always #5 clk = ~clk;

  // Cycle counter and the reset level the DUT actually sampled at each edge.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset_b;
  end

  function automatic int ws_of(input int s);
    return (s == 0) ? 0 : 2;
  endfunction

  function automatic logic [DW-1:0] bus_of(input int s);
    return (s == 0) ? data0 : data1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Behavioural synchronous RAM: registers read data one edge after select.
  logic [DW-1:0] ram     [2][2048];
  logic [DW-1:0] ref_mem [2][2048];
  logic [DW-1:0] ram_q   [2];
  logic          ram_v   [2];

  assign data0 = (ram_v[0] && !cs_b[0] && rnw[0]) ? ram_q[0] : {DW{1'bz}};
  assign data1 = (ram_v[1] && !cs_b[1] && rnw[1]) ? ram_q[1] : {DW{1'bz}};

  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (!cs_b[s] && rnw[s]) begin
        ram_q[s] <= ram[s][address[s]];
        ram_v[s] <= 1'b1;
      end else begin
        ram_v[s] <= 1'b0;
        if (!cs_b[s] && !rnw[s]) ram[s][address[s]] <= bus_of(s);
      end
    end
  end

  // Transaction-level model and bus monitor, sampled on the falling edge.
  txn_t          cur     [2];
  int            run     [2];
  int            gap     [2];
  bit            acc_pend[2];
  logic [DW-1:0] last_rd [2];
  logic          rst_prev = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        if (!rst_q) begin
          check("rst_cs_b",  32'(cs_b[s]), 1);
          check("rst_rnw",   32'(rnw[s]), 1);
          check("rst_ready", 32'(req_ready[s]), 0);
          check("rst_rsp",   32'(rsp_valid[s]), 0);
          check("rst_rdata", 32'(rsp_rdata[s]), 0);
          check("rst_addr",  32'(address[s]), 0);
          cur[s].busy = 1'b0;
          acc_pend[s] = 1'b0;
          run[s]      = 0;
          gap[s]      = 2;
          last_rd[s]  = '0;
        end else begin
          if (!rst_prev) check("release_ready", 32'(req_ready[s]), 1);
          if (acc_pend[s]) begin
            check("c1_cs_b",  32'(cs_b[s]), 0);
            check("c1_ready", 32'(req_ready[s]), 0);
            acc_pend[s] = 1'b0;
          end
          if (!cs_b[s]) begin
            if (run[s] == 0) check("turnaround", 32'(gap[s] >= 2), 1);
            run[s]++;
            gap[s] = 0;
            check("bus_addr", 32'(address[s]), 32'(cur[s].addr));
            check("bus_rnw",  32'(rnw[s]), 32'(cur[s].rnw));
            if (!rnw[s]) check("bus_wdata", 32'(bus_of(s)), 32'(cur[s].wdata));
          end else begin
            if (run[s] != 0)
              check("select_len", 32'(run[s]), 32'((cur[s].rnw ? 2 : 1) + ws_of(s)));
            run[s] = 0;
            if (gap[s] < 1000) gap[s]++;
            check("idle_rnw", 32'(rnw[s]), 1);
          end
          if (rsp_valid[s]) begin
            check("rsp_expected", 32'(cur[s].busy), 1);
            if (cur[s].busy) begin
              check("latency", 32'(cyc - cur[s].acc), 32'((cur[s].rnw ? 3 : 2) + ws_of(s)));
              if (cur[s].rnw) begin
                check("rdata", 32'(rsp_rdata[s]), 32'(cur[s].rdata));
                last_rd[s] = cur[s].rdata;
              end else begin
                check("rdata_hold", 32'(rsp_rdata[s]), 32'(last_rd[s]));
              end
              cur[s].busy = 1'b0;
            end
          end
          if (reset_b && req_valid[s] && req_ready[s]) begin
            check("one_outstanding", 32'(cur[s].busy), 0);
            cur[s].busy  = 1'b1;
            cur[s].rnw   = req_rnw[s];
            cur[s].addr  = req_addr[s];
            cur[s].wdata = req_wdata[s];
            cur[s].acc   = cyc;
            if (req_rnw[s]) begin
              cur[s].rdata = ref_mem[s][req_addr[s]];
            end else begin
              ref_mem[s][req_addr[s]] = req_wdata[s];
              cur[s].rdata = '0;
            end
            acc_pend[s] = 1'b1;
          end
        end
      end
      rst_prev = rst_q;
    end
  end

  // Present a request (called at posedge+2) and hold it until accepted.
  task automatic issue(input int s, input bit r, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input bit keep);
    int t;
    req_valid[s] = 1'b1;
    req_rnw[s]   = r;
    req_addr[s]  = a;
    req_wdata[s] = wd;
    t = 0;
    while (!req_ready[s] && t < 200) begin
      @(posedge clk); #2;
      t++;
    end
    check("accept_wait", 32'(req_ready[s]), 1);
    @(posedge clk); #2;
    if (!keep) req_valid[s] = 1'b0;
  endtask

  task automatic wait_done(input int s);
    int t;
    t = 0;
    while ((cur[s].busy || !req_ready[s]) && t < 200) begin
      @(posedge clk); #2;
      t++;
    end
    check("rsp_wait", 32'(cur[s].busy), 0);
  endtask

  // Wiggle request fields while the block is busy; valid stays low.
  task automatic scramble(input int s, input int n);
    repeat (n) begin
      req_rnw[s]   = 1'($urandom_range(0, 1));
      req_addr[s]  = AW'($urandom);
      req_wdata[s] = DW'($urandom);
      @(posedge clk); #2;
    end
  endtask

  initial begin
    reset_b = 1'b0;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0;
      req_rnw[s]   = 1'b0;
      req_addr[s]  = '0;
      req_wdata[s] = '0;
      ram_v[s]     = 1'b0;
      ram_q[s]     = '0;
      for (int a = 0; a < 2048; a++) begin
        ram[s][a]     = DW'($urandom);
        ref_mem[s][a] = ram[s][a];
      end
    end
    ram[1][11'h7FF]     = 16'h1234;
    ref_mem[1][11'h7FF] = 16'h1234;

    repeat (3) @(posedge clk);
    #2 reset_b = 1'b1;
    @(posedge clk); #2;

    // Write then read back with no wait states; fields change while busy.
    issue(0, 1'b0, 11'h123, 16'hBEEF, 1'b0);
    wait_done(0);
    issue(0, 1'b1, 11'h123, 16'h0000, 1'b0);
    scramble(0, 1);
    wait_done(0);

    // Top address with two wait states, then a write that must leave rdata alone.
    issue(1, 1'b1, 11'h7FF, 16'h0000, 1'b0);
    scramble(1, 3);
    wait_done(1);
    issue(1, 1'b0, 11'h010, 16'hA5A5, 1'b0);
    wait_done(1);

    // Back-to-back alternating writes/reads with valid held high.
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 8; k++)
        issue(s, 1'(k % 2), AW'(k), DW'($urandom), 1'b1);
      req_valid[s] = 1'b0;
      wait_done(s);
    end

    // Random traffic: valid may drop unaccepted, fields change every cycle.
    for (int i = 0; i < 400; i++) begin
      for (int s = 0; s < 2; s++) begin
        req_valid[s] = ($urandom_range(0, 2) == 0);
        req_rnw[s]   = 1'($urandom_range(0, 1));
        req_addr[s]  = ($urandom_range(0, 3) == 0) ? AW'(11'h7F8 + $urandom_range(0, 7))
                                                   : AW'($urandom_range(0, 7));
        req_wdata[s] = DW'($urandom);
      end
      @(posedge clk); #2;
    end
    for (int s = 0; s < 2; s++) req_valid[s] = 1'b0;
    wait_done(0);
    wait_done(1);

    // Reset during a read: the aborted request must never respond.
    issue(1, 1'b1, 11'h005, 16'h0000, 1'b0);
    reset_b = 1'b0;
    repeat (3) begin
      @(posedge clk); #2;
    end
    reset_b = 1'b1;
    @(posedge clk); #2;

    // Recovery traffic on both instances.
    issue(1, 1'b1, 11'h005, 16'h0000, 1'b0);
    wait_done(1);
    issue(0, 1'b0, 11'h3C0, 16'h5A5A, 1'b0);
    wait_done(0);
    issue(0, 1'b1, 11'h3C0, 16'h0000, 1'b0);
    wait_done(0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
